sobel_window_builder: RTL and testbench
=======================================

// Module: sobel_window_builder
// PURPOSE
//  Upstream feeder for sobel_edge_detector. Accepts a raster-order pixel stream (valid/ready) into a
//  4-row circular line buffer. Serves 4x4 windows at stride 2 in both directions to the detector,
//  using its need_data / bus_data_ready handshake. One window yields the detector's 2x2 output block.
// PARAMETERS
//  IMG_WIDTH       400  pixels per row; even, >= 4
//  IMG_HEIGHT      300  rows per frame; even, >= 4
//  BITS_PER_PIXEL  4    pixel width
// PORTS
//  clk             in   1                      system clock; one clock domain, rising edge only
//  rst             in   1                      reset; asynchronous, active-high
//  pixel_in        in   BITS_PER_PIXEL         stream pixel, raster order (row-major)
//  pixel_valid     in   1                      pixel_in is valid
//  pixel_ready     out  1                      block can accept a pixel
//  need_data       in   1                      detector requests the next window
//  bus_data_ready  out  1                      one-cycle pulse: input_pixels holds a new window
//  input_pixels    out  [3:0][3:0][BITS_PER_PIXEL-1:0]  window; [i][j] = pixel(r+i, c+j)
//  frame_done      out  1                      one-cycle pulse after the frame's last window
// BEHAVIOUR
//  Reset (async, rst=1)
//   - State goes to FILL and all counters clear.
//   - Buffered rows are discarded; the armed flag is set to 1.
//   - bus_data_ready=0, frame_done=0, input_pixels=0.
//   - pixel_ready=0 while rst is high; pixel_ready=1 from the first cycle after release.
//   - Reset mid-frame aborts the frame; the next pixel accepted is treated as pixel(0,0).
//  Pixel intake
//   - A transfer happens on a rising edge with pixel_valid & pixel_ready.
//   - Pixel is written to slot[row%4][col]. col wraps IMG_WIDTH-1 -> 0 and row increments.
//   - Counters are $clog2 sized. Gaps in pixel_valid are tolerated.
//  FSM: FILL -> EMIT -> (FILL | DONE); pixel_ready = (state==FILL); all outputs registered
//   - FILL: accept rows until the band is complete.
//       - First band: 4 rows (4*IMG_WIDTH transfers). Later bands: 2 rows.
//       - The edge that takes the last pixel moves the state to EMIT. pixel_ready is 0 the next cycle.
//       - need_data is ignored in FILL.
//   - EMIT: band base row r (even), window column c = 0,2,...,IMG_WIDTH-4; that is IMG_WIDTH/2-1 windows.
//       - Issue: an edge with need_data=1 and armed=1 loads window (r,c) into input_pixels.
//         bus_data_ready=1 for exactly the next cycle. armed clears and c advances by 2.
//       - Re-arm: armed sets on any edge that samples need_data=0.
//         If need_data is held high, no further pulse is issued.
//       - input_pixels holds stable until the next issue.
//       - After the last window of a band:
//           - if r+4 < IMG_HEIGHT: r += 2, go to FILL with need = 2 rows.
//             New rows overwrite slots r%4 and (r+1)%4, the oldest rows.
//           - else go to DONE.
//   - DONE: frame_done=1 for one cycle; counters and r clear; next state FILL (first band, 4 rows).
//   - Totals: IMG_HEIGHT/2-1 bands per frame. Every input row is consumed exactly once.
//  Window row i maps to slot (r+i)%4, so the window rotates correctly across slot wrap.
//  The write of the last pixel and the state change happen on the same edge.
//  The first window can issue at the earliest one edge later.
// TESTING
//  1 Reset mid-fill:
//      - 20 pixels in, then rst pulse -> all outputs 0, pixel_ready=0 during rst, 1 after release.
//      - The next pixel is stored as (0,0).
//  2 WIDTH=8, HEIGHT=6, pixel(r,c)=(r*8+c)%16, model detector:
//      - Exactly 6 pulses in order (0,0),(0,2),(0,4),(2,0),(2,2),(2,4).
//      - At window (0,2), input_pixels[1][3]=13.
//      - At window (2,4), input_pixels[3][3]=15.
//  3 First fill with random valid gaps:
//      - pixel_ready stays 1 for exactly 32 transfers, then 0.
//      - No pulse is issued before the 32nd transfer.
//  4 need_data held high for 10 cycles in EMIT -> exactly one bus_data_ready pulse.
//      - Drop for 1 cycle, then raise -> the next window is issued.
//  5 After band 0 -> exactly 16 transfers accepted (2 rows).
//      - frame_done pulses once, 1 cycle after the last window's pulse.
//      - A second frame then runs with identical results.
//  6 need_data=1 throughout FILL -> bus_data_ready stays 0 until EMIT is entered.

Source files
------------

// File: rtl/sobel_window_builder.sv
`default_nettype none
// =============================================================================
// sobel_window_builder : 4-row circular line buffer serving 4x4 stride-2
//                        windows to sobel_edge_detector
// Revision 1.0
// =============================================================================
module sobel_window_builder #(
   parameter int IMG_WIDTH      = 400,
   parameter int IMG_HEIGHT     = 300,
   parameter int BITS_PER_PIXEL = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [BITS_PER_PIXEL-1:0]               pixel_in,
   input  logic                                    pixel_valid,
   output logic                                    pixel_ready,
   input  logic                                    need_data,
   output logic                                    bus_data_ready,
   output logic [3:0][3:0][BITS_PER_PIXEL-1:0]     input_pixels,
   output logic                                    frame_done
);

   localparam int c_col_w = $clog2(IMG_WIDTH);
   localparam int c_row_w = $clog2(IMG_HEIGHT);

   localparam logic [1:0] c_st_fill = 2'd0;
   localparam logic [1:0] c_st_emit = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(IMG_WIDTH - 1);
   localparam logic [c_col_w-1:0] c_wcol_last = c_col_w'(IMG_WIDTH - 4);

   logic [1:0]                              state_q, state_d;
   logic [c_col_w-1:0]                      col_q, col_d;
   logic [c_row_w-1:0]                      row_q, row_d;
   logic [c_row_w-1:0]                      base_q, base_d;
   logic [c_col_w-1:0]                      wcol_q, wcol_d;
   logic                                    armed_q, armed_d;
   logic                                    ready_q, ready_d;
   logic                                    bdr_q, bdr_d;
   logic                                    fdone_q, fdone_d;
   logic [3:0][3:0][BITS_PER_PIXEL-1:0]     win_q, win_d;
   logic                                    wr_en;

   logic [BITS_PER_PIXEL-1:0] line_buf_q [4][IMG_WIDTH];

   // Buffer contents need no reset: the counters decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_buf_q[row_q[1:0]][col_q] <= pixel_in;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      base_d  = base_q;
      wcol_d  = wcol_q;
      armed_d = armed_q;
      win_d   = win_q;
      bdr_d   = 1'b0;
      fdone_d = 1'b0;
      wr_en   = 1'b0;

      if (!need_data) begin
         armed_d = 1'b1;
      end

      case (state_q)
         c_st_fill: begin
            if (pixel_valid && ready_q) begin
               wr_en = 1'b1;
               if (col_q == c_col_last) begin
                  col_d = '0;
                  row_d = row_q + c_row_w'(1);
                  // A band always ends on row base+3, first band included.
                  if (row_q == base_q + c_row_w'(3)) begin
                     state_d = c_st_emit;
                  end
               end else begin
                  col_d = col_q + c_col_w'(1);
               end
            end
         end
         c_st_emit: begin
            if (need_data && armed_q) begin
               for (int i = 0; i < 4; i++) begin
                  for (int j = 0; j < 4; j++) begin
                     win_d[i][j] = line_buf_q[base_q[1:0] + 2'(i)][wcol_q + c_col_w'(j)];
                  end
               end
               bdr_d   = 1'b1;
               armed_d = 1'b0;
               if (wcol_q == c_wcol_last) begin
                  wcol_d = '0;
                  if (int'(base_q) + 4 < IMG_HEIGHT) begin
                     base_d  = base_q + c_row_w'(2);
                     state_d = c_st_fill;
                  end else begin
                     state_d = c_st_done;
                  end
               end else begin
                  wcol_d = wcol_q + c_col_w'(2);
               end
            end
         end
         c_st_done: begin
            fdone_d = 1'b1;
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
            wcol_d  = '0;
            state_d = c_st_fill;
         end
         default: begin
            state_d = c_st_fill;
         end
      endcase

      ready_d = (state_d == c_st_fill);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_st_fill;
         col_q   <= '0;
         row_q   <= '0;
         base_q  <= '0;
         wcol_q  <= '0;
         armed_q <= 1'b1;
         ready_q <= 1'b0;
         bdr_q   <= 1'b0;
         fdone_q <= 1'b0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         base_q  <= base_d;
         wcol_q  <= wcol_d;
         armed_q <= armed_d;
         ready_q <= ready_d;
         bdr_q   <= bdr_d;
         fdone_q <= fdone_d;
         win_q   <= win_d;
      end
   end

   assign pixel_ready    = ready_q;
   assign bus_data_ready = bdr_q;
   assign frame_done     = fdone_q;
   assign input_pixels   = win_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_builder.sv
`default_nettype none
// =============================================================================
// tb_sobel_window_builder : scoreboard bench for sobel_window_builder
// Revision 1.0
// =============================================================================
module tb_sobel_window_builder;

   localparam int IMG_W = 8;
   localparam int IMG_H = 6;
   localparam int BPP   = 4;
   localparam int WIN_PER_FRAME = (IMG_W / 2 - 1) * (IMG_H / 2 - 1);

   typedef struct {
      logic [3:0][3:0][BPP-1:0] win;
      int  r;
      int  c;
      bit  last;
      bit  pat;
      int  req;
   } exp_t;

   logic                      clk;
   logic                      rst;
   logic [BPP-1:0]            pixel_in;
   logic                      pixel_valid;
   logic                      pixel_ready;
   logic                      need_data;
   logic                      bus_data_ready;
   logic [3:0][3:0][BPP-1:0]  input_pixels;
   logic                      frame_done;

   sobel_window_builder #(
      .IMG_WIDTH      (IMG_W),
      .IMG_HEIGHT     (IMG_H),
      .BITS_PER_PIXEL (BPP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pixel_in       (pixel_in),
      .pixel_valid    (pixel_valid),
      .pixel_ready    (pixel_ready),
      .need_data      (need_data),
      .bus_data_ready (bus_data_ready),
      .input_pixels   (input_pixels),
      .frame_done     (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [BPP-1:0] pix_q [$];
   exp_t           exp_q [$];
   int             fall_q [$];
   int pix_idx, frame_start, n_vec, n_fail, n_pulses, n_frames, n_falls;
   int det_mode;
   logic need_force;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endfunction

   task automatic report_timeout(string name);
      n_vec++;
      n_fail++;
      $display("FAIL timeout_%s: got no event expected event within budget", name);
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Reference image -> expected windows, band-end transfer counts
   task automatic push_frame(bit pat);
      logic [BPP-1:0] img [IMG_H][IMG_W];
      exp_t e;
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            img[r][c] = pat ? BPP'((r * IMG_W + c) % 16) : BPP'($urandom);
            pix_q.push_back(img[r][c]);
         end
      end
      for (int b = 0; b < IMG_H / 2 - 1; b++) begin
         fall_q.push_back(frame_start + (2 * b + 4) * IMG_W);
         for (int c = 0; c <= IMG_W - 4; c += 2) begin
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  e.win[i][j] = img[2 * b + i][c + j];
            e.r    = 2 * b;
            e.c    = c;
            e.last = (b == IMG_H / 2 - 2) && (c == IMG_W - 4);
            e.pat  = pat;
            e.req  = frame_start + (2 * b + 4) * IMG_W;
            exp_q.push_back(e);
         end
      end
      frame_start += IMG_W * IMG_H;
   endtask

   task automatic feeder_loop();
      forever begin
         @(negedge clk);
         if (rst) begin
            pix_idx     = 0;
            pixel_valid = 1'b0;
         end else if (pix_idx < pix_q.size()) begin
            pixel_valid = ($urandom_range(0, 3) != 0);
            pixel_in    = pix_q[pix_idx];
            if (pixel_valid && pixel_ready) pix_idx++;
         end else begin
            pixel_valid = 1'b0;
         end
      end
   endtask

   task automatic detector_loop();
      forever begin
         @(negedge clk);
         case (det_mode)
            1:       need_data = need_force;
            2:       need_data = ($urandom_range(0, 2) != 0);
            default: need_data = 1'b0;
         endcase
      end
   endtask

   task automatic monitor_loop();
      bit   fd_pend = 1'b0;
      bit   fd_exp;
      logic prev_ready = 1'b0;
      exp_t e;
      int   want;
      forever begin
         @(negedge clk);
         fd_exp  = fd_pend;
         fd_pend = 1'b0;
         if (bus_data_ready) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("window_r%0d_c%0d", e.r, e.c), 64'(input_pixels), 64'(e.win));
               chk($sformatf("pulse_before_band_r%0d", e.r), 64'(pix_idx >= e.req), 64'(1));
               if (e.pat && e.r == 0 && e.c == 2)
                  chk("win02_px13", 64'(input_pixels[1][3]), 64'(13));
               if (e.pat && e.r == 2 && e.c == 4)
                  chk("win24_px33", 64'(input_pixels[3][3]), 64'(15));
               if (e.last) fd_pend = 1'b1;
            end
         end
         if (fd_exp || frame_done) begin
            chk("frame_done_timing", 64'(frame_done), 64'(fd_exp));
            if (frame_done) n_frames++;
         end
         if (prev_ready && !pixel_ready && !rst) begin
            n_falls++;
            if (fall_q.size() == 0) begin
               chk("unexpected_ready_drop", 64'(1), 64'(0));
            end else begin
               want = fall_q.pop_front();
               chk("transfers_at_band_end", 64'(pix_idx), 64'(want));
            end
         end
         prev_ready = pixel_ready;
      end
   endtask

   task automatic wait_frames(int target, string name);
      int t = 0;
      while (n_frames < target && t < 3000) begin
         step(1);
         t++;
      end
      if (n_frames < target) report_timeout(name);
   endtask

   initial begin
      int t;
      int base_p;
      int base_f;
      rst         = 1'b1;
      pixel_valid = 1'b0;
      pixel_in    = '0;
      need_data   = 1'b0;
      need_force  = 1'b0;
      det_mode    = 0;
      pix_idx     = 0;
      frame_start = 0;
      n_vec       = 0;
      n_fail      = 0;
      n_pulses    = 0;
      n_frames    = 0;
      n_falls     = 0;
      fork
         feeder_loop();
         detector_loop();
         monitor_loop();
      join_none

      step(3);
      chk("rst_pixel_ready", 64'(pixel_ready), 64'(0));
      chk("rst_bus_data_ready", 64'(bus_data_ready), 64'(0));
      chk("rst_frame_done", 64'(frame_done), 64'(0));
      chk("rst_input_pixels", 64'(input_pixels), 64'(0));
      rst = 1'b0;
      step(1);
      chk("ready_after_release", 64'(pixel_ready), 64'(1));

      // Partial fill, then abort it with a reset
      repeat (20) pix_q.push_back(BPP'($urandom));
      t = 0;
      while (pix_idx < 20 && t < 500) begin
         step(1);
         t++;
      end
      if (pix_idx < 20) report_timeout("partial_fill");
      step(2);
      rst = 1'b1;
      #1;
      chk("midrst_pixel_ready", 64'(pixel_ready), 64'(0));
      step(2);
      chk("midrst_outputs", 64'({bus_data_ready, frame_done, pixel_ready}), 64'(0));
      chk("midrst_input_pixels", 64'(input_pixels), 64'(0));
      pix_q.delete();
      frame_start = 0;
      rst = 1'b0;
      step(1);
      chk("midrst_ready_after_release", 64'(pixel_ready), 64'(1));

      // Frame A: pattern image, random detector
      det_mode = 2;
      push_frame(1'b1);
      wait_frames(1, "frame_a");
      chk("frame_a_pulses", 64'(n_pulses), 64'(WIN_PER_FRAME));

      // Frame B: need_data high through fill, then held high in EMIT
      det_mode   = 1;
      need_force = 1'b0;
      step(2);
      need_force = 1'b1;
      base_p = n_pulses;
      base_f = n_falls;
      push_frame(1'b1);
      t = 0;
      while (n_falls == base_f && t < 1000) begin
         step(1);
         t++;
      end
      if (n_falls == base_f) report_timeout("frame_b_fill");
      step(10);
      chk("held_need_single_pulse", 64'(n_pulses - base_p), 64'(1));
      need_force = 1'b0;
      step(1);
      need_force = 1'b1;
      step(3);
      chk("rearm_next_pulse", 64'(n_pulses - base_p), 64'(2));
      det_mode = 2;
      wait_frames(2, "frame_b");
      chk("frame_b_pulses", 64'(n_pulses - base_p), 64'(WIN_PER_FRAME));

      // Frame C: random image
      push_frame(1'b0);
      wait_frames(3, "frame_c");
      step(5);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      chk("band_ends_consumed", 64'(fall_q.size()), 64'(0));
      chk("frames_seen", 64'(n_frames), 64'(3));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
